nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder for the calculator datapath; complements the 4-bit subtractor path.

---
 rtl/calc_pkg.sv | 16 +
 rtl/nibble_serial_adder_if.sv | 33 +++
 rtl/adder_4_bit_cin.sv | 12 +
 rtl/nibble_serial_adder.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared constants, state encoding and nibble-count helper for the calculator datapath.
package calc_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibble_count(input int width);
    return width / CHUNK_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the nibble-serial adder.
// The ovf signal exists only when CALC_OVF_FLAG_EN is defined.
interface nibble_serial_adder_if #(parameter int WIDTH = 8);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CALC_OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef CALC_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef CALC_OVF_FLAG_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/adder_4_bit_cin.sv
// Combinational 4-bit adder with carry-in; produces the full 5-bit result as {o_cout, o_s}.
module adder_4_bit_cin (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);

  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock through a single shared 4-bit adder.
// Optional signed-overflow output enabled by defining CALC_OVF_FLAG_EN.
module nibble_serial_adder
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int              N        = nibble_count(WIDTH);
  localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic [WIDTH-1:0]   w_sumNext;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_idx;
  logic [CHUNK_W-1:0] w_aNib;
  logic [CHUNK_W-1:0] w_bNib;
  logic [CHUNK_W-1:0] w_s;
  logic               w_c;
  logic               w_last;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;

  assign w_aNib   = r_a[int'(r_idx)*CHUNK_W +: CHUNK_W];
  assign w_bNib   = r_b[int'(r_idx)*CHUNK_W +: CHUNK_W];
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = (r_state == IDLE) && bus.start;

  adder_4_bit_cin u_adder (
    .i_a    (w_aNib),
    .i_b    (w_bNib),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  // Full result as it will look once the MSB nibble lands; only consumed on the last step.
  always_comb begin
    w_sumNext = r_acc;
    w_sumNext[WIDTH-1 -: CHUNK_W] = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_nextState = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_nextState = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_acc   <= '0;
      r_carry <= bus.cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_acc[int'(r_idx)*CHUNK_W +: CHUNK_W] <= w_s;
      r_carry <= w_c;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_sum  <= w_sumNext;
        r_cout <= w_c;
      end
    end
  end

`ifdef CALC_OVF_FLAG_EN
  logic r_ovf;

  // Overflow when both operands share a sign that the result does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sumNext[WIDTH-1] != r_a[WIDTH-1]);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: an 8-bit and a 16-bit instance on one clock.
// Overflow checks are included when CALC_OVF_FLAG_EN is defined.
module tb_nibble_serial_adder;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   lat;
  int   busyN;
  int   overlap;
  int   doneCnt;

  nibble_serial_adder_if #(.WIDTH(8))  bus8  ();
  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents start for exactly one rising edge (E0); returns just after E0.
  task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    if (wide) begin
      bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.start = 1'b1;
    end else begin
      bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin; bus8.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen; lat stays -1 if the budget runs out.
  task automatic waitDone(input bit wide, output int latOut, output int busyOut, output int overlapOut);
    logic bsy;
    logic dn;
    latOut = -1; busyOut = 0; overlapOut = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bsy = wide ? bus16.busy : bus8.busy;
      dn  = wide ? bus16.done : bus8.done;
      if (bsy) busyOut++;
      if (bsy && dn) overlapOut++;
      if (dn) begin
        latOut = i;
        break;
      end
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_busy", 32'(bus8.busy), 32'd0);
    checkOutput("reset_done", 32'(bus8.done), 32'd0);
    checkOutput("reset_sum",  32'(bus8.sum),  32'd0);
    checkOutput("reset_cout", 32'(bus8.cout), 32'd0);
`ifdef CALC_OVF_FLAG_EN
    checkOutput("reset_ovf",  32'(bus8.ovf),  32'd0);
`endif
    rst_n = 1'b1;

    $display("[TB] test1: 0F + 01, carry crosses nibble boundary");
    applyStimulus(1'b0, 16'h000F, 16'h0001, 1'b0);
    waitDone(1'b0, lat, busyN, overlap);
    checkOutput("t1_latency", 32'(lat),     32'd2);
    checkOutput("t1_busy",    32'(busyN),   32'd2);
    checkOutput("t1_overlap", 32'(overlap), 32'd0);
    checkOutput("t1_sum",     32'(bus8.sum),  32'h10);
    checkOutput("t1_cout",    32'(bus8.cout), 32'd0);
    @(negedge clk);
    checkOutput("t1_done_pulse", 32'(bus8.done), 32'd0);
    checkOutput("t1_sum_held",   32'(bus8.sum),  32'h10);

    $display("[TB] test2: FF + 01 wraps");
    applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0);
    waitDone(1'b0, lat, busyN, overlap);
    checkOutput("t2_latency", 32'(lat),       32'd2);
    checkOutput("t2_sum",     32'(bus8.sum),  32'h00);
    checkOutput("t2_cout",    32'(bus8.cout), 32'd1);
`ifdef CALC_OVF_FLAG_EN
    checkOutput("t2_ovf",     32'(bus8.ovf),  32'd0);
`endif

    $display("[TB] test3: 7F + 01 and 80 + 80");
    applyStimulus(1'b0, 16'h007F, 16'h0001, 1'b0);
    waitDone(1'b0, lat, busyN, overlap);
    checkOutput("t3a_sum",  32'(bus8.sum),  32'h80);
    checkOutput("t3a_cout", 32'(bus8.cout), 32'd0);
`ifdef CALC_OVF_FLAG_EN
    checkOutput("t3a_ovf",  32'(bus8.ovf),  32'd1);
`endif
    applyStimulus(1'b0, 16'h0080, 16'h0080, 1'b0);
    waitDone(1'b0, lat, busyN, overlap);
    checkOutput("t3b_sum",  32'(bus8.sum),  32'h00);
    checkOutput("t3b_cout", 32'(bus8.cout), 32'd1);
`ifdef CALC_OVF_FLAG_EN
    checkOutput("t3b_ovf",  32'(bus8.ovf),  32'd1);
`endif

    $display("[TB] test4: FF + FF + 1 with a start pulse during RUN");
    applyStimulus(1'b0, 16'h00FF, 16'h00FF, 1'b1);
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b0;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus8.done) doneCnt++;
    end
    checkOutput("t4_done_count", 32'(doneCnt),   32'd1);
    checkOutput("t4_sum",        32'(bus8.sum),  32'hFF);
    checkOutput("t4_cout",       32'(bus8.cout), 32'd1);
    checkOutput("t4_idle_busy",  32'(bus8.busy), 32'd0);

    $display("[TB] test5: reset during RUN of 12 + 34");
    applyStimulus(1'b0, 16'h0012, 16'h0034, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", 32'(bus8.busy), 32'd0);
    checkOutput("t5_done", 32'(bus8.done), 32'd0);
    checkOutput("t5_sum",  32'(bus8.sum),  32'd0);
    checkOutput("t5_cout", 32'(bus8.cout), 32'd0);
    doneCnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus8.done) doneCnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus8.done) doneCnt++;
    end
    checkOutput("t5_no_done", 32'(doneCnt), 32'd0);
    applyStimulus(1'b0, 16'h0012, 16'h0034, 1'b0);
    waitDone(1'b0, lat, busyN, overlap);
    checkOutput("t5_retry_lat", 32'(lat),       32'd2);
    checkOutput("t5_retry_sum", 32'(bus8.sum),  32'h46);

    $display("[TB] test6: WIDTH=16 operations");
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    waitDone(1'b1, lat, busyN, overlap);
    checkOutput("t6_latency", 32'(lat),        32'd4);
    checkOutput("t6_busy",    32'(busyN),      32'd4);
    checkOutput("t6_overlap", 32'(overlap),    32'd0);
    checkOutput("t6_sum",     32'(bus16.sum),  32'h0000);
    checkOutput("t6_cout",    32'(bus16.cout), 32'd1);

    applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b1);
    waitDone(1'b1, lat, busyN, overlap);
    checkOutput("t6_b2b1_lat", 32'(lat),        32'd4);
    checkOutput("t6_b2b1_sum", 32'(bus16.sum),  32'h5556);
    checkOutput("t6_b2b1_cout", 32'(bus16.cout), 32'd0);
    applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0);
    waitDone(1'b1, lat, busyN, overlap);
    checkOutput("t6_b2b2_lat", 32'(lat),        32'd4);
    checkOutput("t6_b2b2_sum", 32'(bus16.sum),  32'h0000);
    checkOutput("t6_b2b2_cout", 32'(bus16.cout), 32'd1);
`ifdef CALC_OVF_FLAG_EN
    checkOutput("t6_b2b2_ovf", 32'(bus16.ovf),  32'd1);
`endif
    applyStimulus(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
    waitDone(1'b1, lat, busyN, overlap);
    checkOutput("t6_b2b3_lat", 32'(lat),        32'd4);
    checkOutput("t6_b2b3_sum", 32'(bus16.sum),  32'h1000);
    checkOutput("t6_b2b3_cout", 32'(bus16.cout), 32'd0);
    checkOutput("t6_w8_untouched", 32'(bus8.sum), 32'h46);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
